equ_8bit: RTL and testbench
===========================

# equ_8bit

Registered 8-bit equality comparator. It compares two 8-bit two's-complement operands and reports equality one clock after the operands are sampled, together with a per-bit mismatch mask and an output-valid flag. It serves as a leaf compare stage in datapaths that need a pipelined equal/not-equal decision, and optionally a signed ordering decision.

## Interface
Parameters:
- none; operand width is fixed at 8 bits.

Ports:
- clk   input   1   rising-edge clock; the only clock.
- rst_n input   1   reset, asynchronous, active-low.
- en    input   1   operand-valid strobe; x and y are sampled on rising clk when en=1.
- x     input   8   operand x, signed two's-complement.
- y     input   8   operand y, signed two's-complement.
- r     output  1   registered result: 1 when sampled x equals sampled y bit-for-bit.
- diff  output  8   registered mismatch mask, x XOR y; bit i=1 when bit i differs.
- vld   output  1   registered: 1 for exactly the cycle after an en=1 sample.
- lt    output  1   present only with EQU_8BIT_CMP_EN; registered signed x < y.
- gt    output  1   present only with EQU_8BIT_CMP_EN; registered signed x > y.

## Operation
- Equality is bit-exact over all 8 bits. Signedness does not affect r: -128 (0x80) equals only 0x80.
- r is 1 exactly when diff is 0x00. It is computed from the same sampled operands as diff.
- On a rising clk with en=1:
  - r, diff, lt and gt load results for the current x and y.
  - vld goes to 1.
- On a rising clk with en=0:
  - r, diff, lt and gt hold their previous values.
  - vld goes to 0.
- lt and gt use signed 8-bit comparison. At most one of r, lt and gt is 1 after any sample.
- There are no internal state machines or counters. The block is purely combinational logic plus one register stage.
- Operands with X or Z bits are outside the contract.

## Timing
- Latency is 1 cycle. Operands presented with en=1 before edge N appear on r, diff, lt, gt and vld after edge N.
- Throughput is one compare per cycle. Back-to-back en=1 cycles give back-to-back results, and vld stays 1.
- Reset: when rst_n is low, r, diff, lt, gt and vld clear to 0 immediately, without waiting for clk.
- Reset is released synchronously with clk. The first edge with rst_n=1 and en=1 produces a valid result.
- Reset mid-operation: an in-flight result is discarded. vld is 0 until a new en=1 sample occurs.
- Inputs must meet setup and hold to rising clk. The outputs have no combinational path from the inputs.

## Configuration
- Macro: EQU_8BIT_CMP_EN.
- Defined:
  - lt and gt ports exist.
  - They are computed with signed semantics and registered, following the same en, hold and reset rules as r.
- Undefined:
  - lt and gt ports and their logic are absent.
  - r, diff and vld behave identically in both builds.

## Test plan
- Reset with rst_n=0 mid-cycle and no clk edge -> r=0, diff=0x00, vld=0 (lt=0, gt=0) immediately.
- en=1, x=5, y=5, one edge -> r=1, diff=0x00, vld=1; with the macro, lt=0 and gt=0.
- en=1, x=-7 (0xF9), y=5 (0x05) -> r=0, diff=0xFC, vld=1; with the macro, lt=1 and gt=0.
- en=1, x=-128, y=-128, then next cycle x=127, y=-128 -> first r=1, diff=0x00; then r=0, diff=0xFF, and with the macro gt=1.
- Load x=3, y=3, then en=0 with x=1, y=2 for 3 cycles -> r stays 1 and diff stays 0x00; vld=1 for one cycle, then 0.
- en=1 with x=9, y=9 and rst_n asserted before the next edge -> all outputs 0. After release, the first en=1 edge with x=9, y=8 gives r=0, diff=0x01, vld=1.

Source files
------------

// File: rtl/equ_8bit.sv
// equ_8bit: registered 8-bit equality comparator.
// Samples x and y when en=1 and, one clock later, presents the equality
// flag r, the per-bit mismatch mask diff and the output-valid flag vld.
// Optional feature macro: EQU_8BIT_CMP_EN adds registered signed lt/gt
// outputs that follow the same load, hold and reset rules as r.
`timescale 1ns/1ps

module equ_8bit (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic signed [7:0] x,
   input  logic signed [7:0] y,
   output logic              r,
   output logic [7:0]        diff,
   output logic              vld
`ifdef EQU_8BIT_CMP_EN
   ,
   output logic              lt,
   output logic              gt
`endif
);

   localparam int DATA_W = 8;

   // Bit-exact mismatch mask; signedness plays no part in equality.
   function automatic logic [DATA_W-1:0] mismatch_mask(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      return a ^ b;
   endfunction

   // Equal exactly when no bit differs, so r and diff can never disagree.
   function automatic logic all_clear(input logic [DATA_W-1:0] m);
      return (m == '0);
   endfunction

   // ---- Stage p0: combinational compare of the live operands ----
   logic [DATA_W-1:0] diff_p0;
   logic              r_p0;

`ifdef EQU_8BIT_CMP_EN
   // Signed ordering; both operands are declared signed so the relational
   // operators use two's-complement semantics (0x80 is the minimum).
   function automatic logic signed_less(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      return (a < b);
   endfunction

   logic lt_p0;
   logic gt_p0;
`endif

   // Combinational compare results feeding the output register.
   always_comb begin
      diff_p0 = mismatch_mask(x, y);
      r_p0    = all_clear(diff_p0);
`ifdef EQU_8BIT_CMP_EN
      lt_p0   = signed_less(x, y);
      gt_p0   = signed_less(y, x);
`endif
   end

   // ---- Stage p1: registered outputs ----
   logic [DATA_W-1:0] diff_p1;
   logic              r_p1;
   logic              vld_p1;

   // Valid flag: high only for the cycle after an en=1 sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= en;
      end
   end

   // Result register: loads on en, holds otherwise; reset discards any
   // in-flight result so stale data never appears after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p1    <= 1'b0;
         diff_p1 <= '0;
      end else if (en) begin
         r_p1    <= r_p0;
         diff_p1 <= diff_p0;
      end
   end

`ifdef EQU_8BIT_CMP_EN
   logic lt_p1;
   logic gt_p1;

   // Ordering register: same load/hold/reset behaviour as the equality flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lt_p1 <= 1'b0;
         gt_p1 <= 1'b0;
      end else if (en) begin
         lt_p1 <= lt_p0;
         gt_p1 <= gt_p0;
      end
   end

   assign lt = lt_p1;
   assign gt = gt_p1;
`endif

   assign r    = r_p1;
   assign diff = diff_p1;
   assign vld  = vld_p1;

endmodule

// File: tb/tb_equ_8bit.sv
// Directed self-checking bench for equ_8bit (either build of EQU_8BIT_CMP_EN).
`timescale 1ns/1ps

module tb_equ_8bit;

   logic              clk;
   logic              rst_n;
   logic              en;
   logic signed [7:0] x;
   logic signed [7:0] y;
   logic              r;
   logic [7:0]        diff;
   logic              vld;
`ifdef EQU_8BIT_CMP_EN
   logic              lt;
   logic              gt;
`endif

   int checks;
   int failures;

   equ_8bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .x     (x),
      .y     (y),
      .r     (r),
      .diff  (diff),
      .vld   (vld)
`ifdef EQU_8BIT_CMP_EN
      ,
      .lt    (lt),
      .gt    (gt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive operands on the falling edge, then sample 1ns after the rising edge.
   task automatic step(input logic e, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      en = e;
      x  = a;
      y  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      en    = 1'b0;
      x     = 8'h00;
      y     = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({r, diff, vld} !== {1'b0, 8'h00, 1'b0}) begin
         failures++;
         $display("FAIL reset_init got r=%b diff=%h vld=%b want r=0 diff=00 vld=0", r, diff, vld);
      end
`ifdef EQU_8BIT_CMP_EN
      checks++;
      if ({lt, gt} !== 2'b00) begin
         failures++;
         $display("FAIL reset_init_cmp got lt=%b gt=%b want 00", lt, gt);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_equal;
      step(1'b1, 8'd5, 8'd5);
      checks++;
      if ({r, diff, vld} !== {1'b1, 8'h00, 1'b1}) begin
         failures++;
         $display("FAIL eq_5_5 got r=%b diff=%h vld=%b want r=1 diff=00 vld=1", r, diff, vld);
      end
`ifdef EQU_8BIT_CMP_EN
      checks++;
      if ({lt, gt} !== 2'b00) begin
         failures++;
         $display("FAIL eq_5_5_cmp got lt=%b gt=%b want 00", lt, gt);
      end
`endif
   endtask

   // Async reset asserted mid-cycle must clear outputs with no clock edge.
   task automatic test_async_reset;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({r, diff, vld} !== {1'b0, 8'h00, 1'b0}) begin
         failures++;
         $display("FAIL async_reset got r=%b diff=%h vld=%b want r=0 diff=00 vld=0", r, diff, vld);
      end
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b0;
   endtask

   task automatic test_signed;
      step(1'b1, 8'hF9, 8'h05);
      checks++;
      if ({r, diff, vld} !== {1'b0, 8'hFC, 1'b1}) begin
         failures++;
         $display("FAIL neg7_vs_5 got r=%b diff=%h vld=%b want r=0 diff=fc vld=1", r, diff, vld);
      end
`ifdef EQU_8BIT_CMP_EN
      checks++;
      if ({lt, gt} !== 2'b10) begin
         failures++;
         $display("FAIL neg7_vs_5_cmp got lt=%b gt=%b want 10", lt, gt);
      end
`endif
      step(1'b1, 8'h00, 8'h80);
      checks++;
      if ({r, diff, vld} !== {1'b0, 8'h80, 1'b1}) begin
         failures++;
         $display("FAIL zero_vs_min got r=%b diff=%h vld=%b want r=0 diff=80 vld=1", r, diff, vld);
      end
`ifdef EQU_8BIT_CMP_EN
      checks++;
      if ({lt, gt} !== 2'b01) begin
         failures++;
         $display("FAIL zero_vs_min_cmp got lt=%b gt=%b want 01", lt, gt);
      end
`endif
   endtask

   // Extremes back to back: vld must stay high across consecutive samples.
   task automatic test_back_to_back;
      step(1'b1, 8'h80, 8'h80);
      checks++;
      if ({r, diff, vld} !== {1'b1, 8'h00, 1'b1}) begin
         failures++;
         $display("FAIL min_eq_min got r=%b diff=%h vld=%b want r=1 diff=00 vld=1", r, diff, vld);
      end
      step(1'b1, 8'h7F, 8'h80);
      checks++;
      if ({r, diff, vld} !== {1'b0, 8'hFF, 1'b1}) begin
         failures++;
         $display("FAIL max_vs_min got r=%b diff=%h vld=%b want r=0 diff=ff vld=1", r, diff, vld);
      end
`ifdef EQU_8BIT_CMP_EN
      checks++;
      if ({lt, gt} !== 2'b01) begin
         failures++;
         $display("FAIL max_vs_min_cmp got lt=%b gt=%b want 01", lt, gt);
      end
`endif
   endtask

   task automatic test_hold;
      step(1'b1, 8'd3, 8'd3);
      checks++;
      if ({r, diff, vld} !== {1'b1, 8'h00, 1'b1}) begin
         failures++;
         $display("FAIL hold_load got r=%b diff=%h vld=%b want r=1 diff=00 vld=1", r, diff, vld);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'd1, 8'd2);
         checks++;
         if ({r, diff, vld} !== {1'b1, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL hold_cycle%0d got r=%b diff=%h vld=%b want r=1 diff=00 vld=0", i, r, diff, vld);
         end
`ifdef EQU_8BIT_CMP_EN
         checks++;
         if ({lt, gt} !== 2'b00) begin
            failures++;
            $display("FAIL hold_cycle%0d_cmp got lt=%b gt=%b want 00", i, lt, gt);
         end
`endif
      end
   endtask

   // Sample presented, then reset before the edge: result must be discarded.
   task automatic test_inflight_reset;
      @(negedge clk);
      en = 1'b1;
      x  = 8'd9;
      y  = 8'd9;
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({r, diff, vld} !== {1'b0, 8'h00, 1'b0}) begin
         failures++;
         $display("FAIL inflight_reset got r=%b diff=%h vld=%b want r=0 diff=00 vld=0", r, diff, vld);
      end
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
      x     = 8'd9;
      y     = 8'd8;
      @(posedge clk);
      #1;
      checks++;
      if ({r, diff, vld} !== {1'b0, 8'h01, 1'b1}) begin
         failures++;
         $display("FAIL after_release got r=%b diff=%h vld=%b want r=0 diff=01 vld=1", r, diff, vld);
      end
`ifdef EQU_8BIT_CMP_EN
      checks++;
      if ({lt, gt} !== 2'b01) begin
         failures++;
         $display("FAIL after_release_cmp got lt=%b gt=%b want 01", lt, gt);
      end
`endif
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      x        = 8'h00;
      y        = 8'h00;
      test_reset();
      test_equal();
      test_async_reset();
      test_signed();
      test_back_to_back();
      test_hold();
      test_inflight_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
